// File: rtl/out_seq5_pkg.sv
// out_seq5_pkg: shared types and constants for the out_seq5 pattern sequencer.
package out_seq5_pkg;

  // Width of one output pattern (one bit per output-register input).
  localparam int PAT_W = 5;

  // Sequencer states: IDLE drives the idle value, HOLD presents a word.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Occupancy counter width: must be able to represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_seq5_fifo.sv
// out_seq5_fifo: small synchronous show-ahead FIFO. The head entry is always
// visible on pop_data so the sequencer can pop and use it on the same edge.
// Full is derived from the registered count, so a pop never frees a slot for
// a push in the same cycle.
module out_seq5_fifo
  import out_seq5_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                      CK,
  input  logic                      RST,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: one write-enabled register per entry; contents need no reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CK) begin
        if (do_push && (wr_ptr_q == AW'(gi))) mem_q[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/out_seq5.sv
// out_seq5: pattern sequencer feeding the 5-bit output register stage.
// Words {pattern, hold} are buffered in a FIFO and each pattern is held on
// DOUT for max(hold,1) cycles, back-to-back while words are available.
// Optional sticky underrun flag: define OUT_SEQ5_UNDERRUN_EN.
module out_seq5
  import out_seq5_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               HOLD_W   = 8,
  parameter logic [PAT_W-1:0] IDLE_VAL = 5'b00000
) (
  input  logic                      CK,
  input  logic                      RST,
  input  logic [PAT_W-1:0]          WR_DATA,
  input  logic [HOLD_W-1:0]         WR_HOLD,
  input  logic                      WR_VALID,
  output logic                      WR_READY,
  output logic [PAT_W-1:0]          DOUT,
  output logic                      BUSY,
`ifdef OUT_SEQ5_UNDERRUN_EN
  input  logic                      CLR_UNDERRUN,
  output logic                      UNDERRUN,
`endif
  output logic [level_w(DEPTH)-1:0] LEVEL
);

  localparam int WORD_W = PAT_W + HOLD_W;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]    dout_q, dout_d;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [WORD_W-1:0]   head_word;
  logic [PAT_W-1:0]    head_pat;
  logic [HOLD_W-1:0]   head_hold;
  logic [HOLD_W-1:0]   head_cnt;

  out_seq5_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .CK        (CK),
    .RST       (RST),
    .push      (WR_VALID),
    .push_data ({WR_HOLD, WR_DATA}),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (LEVEL)
  );

  assign WR_READY  = !fifo_full;
  assign head_pat  = head_word[PAT_W-1:0];
  assign head_hold = head_word[WORD_W-1:PAT_W];
  // A hold of zero is treated as a single cycle.
  assign head_cnt  = (head_hold == '0) ? HOLD_W'(1) : head_hold;
  assign DOUT      = dout_q;
  assign BUSY      = (state_q == HOLD);

  // Next-state: pop in IDLE or on the last hold cycle, else count down or go idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dout_d   = head_pat;
          cnt_d    = head_cnt;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q > HOLD_W'(1)) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dout_d   = head_pat;
          cnt_d    = head_cnt;
        end else begin
          dout_d  = IDLE_VAL;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = IDLE_VAL;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, hold counter and DOUT registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= IDLE_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef OUT_SEQ5_UNDERRUN_EN
  logic underrun_q, underrun_d;
  logic underrun_set;

  assign underrun_set = (state_q == HOLD) && (cnt_q == HOLD_W'(1)) && fifo_empty;
  assign UNDERRUN     = underrun_q;

  // Sticky flag: set on the HOLD->IDLE edge; a set beats a same-cycle clear.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set)      underrun_d = 1'b1;
    else if (CLR_UNDERRUN) underrun_d = 1'b0;
  end

  // Underrun flag register.
  always_ff @(posedge CK) begin
    if (RST) underrun_q <= 1'b0;
    else     underrun_q <= underrun_d;
  end
`endif

endmodule
